// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel BCD countdown core: key codes,
// per-channel state encoding and the BCD digit width.
package multi_timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [4:0] KEY_CLR   = 5'd10;
    localparam logic [4:0] KEY_START = 5'd11;
    localparam logic [4:0] KEY_SEL   = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_t;

endpackage

// File: rtl/multi_timer_if.sv
// Keypad stream from the key-function front end into the timer core.
// Handshake: key_valid is a one-cycle strobe qualifying bcd_data; there is
// no ready, the core accepts every strobe in the cycle it is presented.
interface multi_timer_if;
    logic       key_valid;
    logic [4:0] bcd_data;

    modport master (output key_valid, output bcd_data);
    modport slave  (input  key_valid, input  bcd_data);
endinterface

// File: rtl/bcd_down_counter.sv
// DIGITS-wide BCD register with clear, load and decrement-by-one.
// o_one flags that the next decrement reaches zero; a zero count never
// decrements, so the counter cannot underflow.
module bcd_down_counter
    import multi_timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_load,
    input  logic [BCD_W*DIGITS-1:0] i_load_val,
    input  logic                    i_dec,
    output logic [BCD_W*DIGITS-1:0] o_count,
    output logic                    o_one
);
    localparam int BW = BCD_W * DIGITS;

    logic [BW-1:0] count_q, count_d, dec_val;
    logic          borrow;

    // Ripple the borrow from digit 0 upward: 0 becomes 9 and keeps borrowing.
    always_comb begin
        dec_val = count_q;
        borrow  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (borrow) begin
                if (count_q[d*BCD_W +: BCD_W] == 4'd0) begin
                    dec_val[d*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    dec_val[d*BCD_W +: BCD_W] = count_q[d*BCD_W +: BCD_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Next count: clear beats load beats decrement.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = dec_val;
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) count_q <= '0;
        else       count_q <= count_d;
    end

    assign o_count = count_q;
    assign o_one   = (count_q == BW'(1));

endmodule

// File: rtl/multi_timer_core.sv
// NUM_CH independent BCD countdown timers driven by the keypad stream and a
// shared prescaled 1 kHz tick. Optional macro MULTI_TIMER_AUTO_RELOAD_EN
// turns each channel periodic: on reaching zero it reloads its last loaded
// value and keeps running instead of entering DONE.
module multi_timer_core
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_pls_1k,
    multi_timer_if.slave              key_if,
    output logic [BCD_W*DIGITS-1:0]   o_bcd_disp,
    output logic [$clog2(NUM_CH)-1:0] o_ch_sel,
    output logic [NUM_CH-1:0]         o_run,
    output logic [NUM_CH-1:0]         o_fin,
    output logic                      o_fin_pulse,
    output logic [2*NUM_CH-1:0]       o_dbg_state
);
    localparam int BW = BCD_W * DIGITS;
    localparam int SW = $clog2(NUM_CH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [NUM_CH-1:0] fin_q, fin_d;
    logic              fin_pulse_q, fin_pulse_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [BW-1:0]     edit_q, edit_d;
    logic              edit_flag_q, edit_flag_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic              key_digit, key_start, key_clr, key_sel;
    logic [NUM_CH-1:0] cnt_clr, cnt_load, cnt_dec, cnt_one;
    logic [BW-1:0]     cnt_val  [NUM_CH];
    logic [BW-1:0]     load_val [NUM_CH];
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
    logic [BW-1:0]     reload_q [NUM_CH];
    logic [BW-1:0]     reload_d [NUM_CH];
`endif

    // Key decode: one action per strobe, codes above SEL fall through unused.
    always_comb begin
        key_digit = key_if.key_valid && (key_if.bcd_data < 5'd10);
        key_clr   = key_if.key_valid && (key_if.bcd_data == KEY_CLR);
        key_start = key_if.key_valid && (key_if.bcd_data == KEY_START);
        key_sel   = key_if.key_valid && (key_if.bcd_data == KEY_SEL);
    end

    // Free-running prescaler; tick fires on the strobe that wraps it.
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (i_pls_1k) begin
            if (pre_q == PW'(TICK_DIV - 1)) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Edit buffer and channel selection; the buffer always belongs to the selected channel.
    always_comb begin
        edit_d      = edit_q;
        edit_flag_d = edit_flag_q;
        sel_d       = sel_q;
        if (key_digit && (state_q[sel_q] == ST_IDLE)) begin
            edit_d      = (edit_q << BCD_W) | BW'(key_if.bcd_data[3:0]);
            edit_flag_d = 1'b1;
        end else if (key_sel) begin
            sel_d       = (sel_q == SW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
            edit_d      = '0;
            edit_flag_d = 1'b0;
        end else if (key_clr) begin
            edit_d      = '0;
            edit_flag_d = 1'b0;
        end else if (key_start && (state_q[sel_q] == ST_IDLE) && edit_flag_q && (edit_q != '0)) begin
            edit_d      = '0;
            edit_flag_d = 1'b0;
        end
    end

    // Channel FSMs: a START/CLR on the selected channel pre-empts that channel's tick.
    always_comb begin
        fin_pulse_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            fin_d[i]    = fin_q[i];
            cnt_clr[i]  = 1'b0;
            cnt_load[i] = 1'b0;
            cnt_dec[i]  = 1'b0;
            load_val[i] = edit_q;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
            reload_d[i] = reload_q[i];
`endif
            if ((sel_q == SW'(i)) && key_clr) begin
                state_d[i] = ST_IDLE;
                fin_d[i]   = 1'b0;
                cnt_clr[i] = 1'b1;
            end else if ((sel_q == SW'(i)) && key_start) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (edit_flag_q && (edit_q != '0)) begin
                            state_d[i]  = ST_RUN;
                            cnt_load[i] = 1'b1;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
                            reload_d[i] = edit_q;
`endif
                        end
                    end
                    ST_RUN:   state_d[i] = ST_PAUSE;
                    ST_PAUSE: state_d[i] = ST_RUN;
                    default: begin
                        state_d[i] = ST_IDLE;
                        fin_d[i]   = 1'b0;
                        cnt_clr[i] = 1'b1;
                    end
                endcase
            end else if (tick && (state_q[i] == ST_RUN)) begin
                cnt_dec[i] = 1'b1;
                if (cnt_one[i]) begin
                    fin_d[i]    = 1'b1;
                    fin_pulse_d = 1'b1;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
                    cnt_dec[i]  = 1'b0;
                    cnt_load[i] = 1'b1;
                    load_val[i] = reload_q[i];
`else
                    state_d[i]  = ST_DONE;
`endif
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
            fin_q       <= '0;
            fin_pulse_q <= 1'b0;
            sel_q       <= '0;
            edit_q      <= '0;
            edit_flag_q <= 1'b0;
            pre_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
            fin_q       <= fin_d;
            fin_pulse_q <= fin_pulse_d;
            sel_q       <= sel_d;
            edit_q      <= edit_d;
            edit_flag_q <= edit_flag_d;
            pre_q       <= pre_d;
        end
    end

`ifdef MULTI_TIMER_AUTO_RELOAD_EN
    // Last value loaded by START, reused each time the channel wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) reload_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) reload_q[i] <= reload_d[i];
        end
    end
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        bcd_down_counter #(.DIGITS(DIGITS)) u_cnt (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_clr      (cnt_clr[g]),
            .i_load     (cnt_load[g]),
            .i_load_val (load_val[g]),
            .i_dec      (cnt_dec[g]),
            .o_count    (cnt_val[g]),
            .o_one      (cnt_one[g])
        );
    end

    // Output view: straight selection among registered state.
    always_comb begin
        o_bcd_disp  = edit_flag_q ? edit_q : cnt_val[sel_q];
        o_ch_sel    = sel_q;
        o_fin       = fin_q;
        o_fin_pulse = fin_pulse_q;
        for (int i = 0; i < NUM_CH; i++) begin
            o_run[i]            = (state_q[i] == ST_RUN);
            o_dbg_state[2*i +: 2] = state_q[i];
        end
    end

endmodule
